// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-entry elastic stage between two pipeline stages, with flush and NOP bubbles.
// Latency: 1 cycle from a push into an empty stage to out_valid/out_data.
// Backpressure: in_ready drops when all DEPTH entries are held, independent of out_ready.
module pipe_stage_buf #(
    parameter int                 DATA_W   = 64,
    parameter int                 DEPTH    = 2,
    parameter logic [DATA_W-1:0]  NOP_DATA = '0,
    localparam int                CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     count
);

    localparam int             PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]  LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    if (DEPTH < 1 || DATA_W < 1) begin : g_param_check
        $error("pipe_stage_buf: DEPTH and DATA_W must both be >= 1");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [CW-1:0]     cnt;
    logic              push;
    logic              pop;

    // Ready/valid come from the occupancy counter only, so no combinational
    // path runs from out_ready back to in_ready.
    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem[rp] : NOP_DATA;
    assign count     = cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (flush) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= ptr_inc(wp);
            if (pop)  rp <= ptr_inc(rp);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

    // Payload storage is not reset; it is only visible through out_data while cnt != 0.
    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wp] <= in_data;
    end

endmodule
